// File: rtl/sha_sched_ctrl.sv
// SHA-256 message-schedule round sequencer: loads one 512-bit block, then streams W[t]
// with its round index over a valid/ready handshake, expanding the 16-word window in place.
module sha_sched_ctrl #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORD_S = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [16*WORD_S-1:0]   blk_data_i,
    input  logic                   abort_i,
    output logic                   rnd_valid_o,
    input  logic                   rnd_ready_i,
    output logic [5:0]             rnd_idx_o,
    output logic [WORD_S-1:0]      rnd_w_o,
    output logic                   rnd_last_o,
    output logic                   done_o,
    output logic                   busy_o
);

    localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              rst_q;
    logic [5:0]        t_q, t_d;
    logic [WORD_S-1:0] win_q [16];
    logic [WORD_S-1:0] win_d [16];
    logic              blk_hs, rnd_hs;

    function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_S - n));
    endfunction

    function automatic logic [WORD_S-1:0] sig0(input logic [WORD_S-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_S-1:0] sig1(input logic [WORD_S-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Abort outranks both handshakes in the same cycle.
    assign blk_hs = blk_valid_i & blk_ready_o & ~abort_i;
    assign rnd_hs = rnd_valid_o & rnd_ready_i & ~abort_i;

    always_ff @(posedge clk_i) begin
        rst_q <= reset_i;
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (blk_hs) state_d = StRun;
            StRun:   if (rnd_hs && rnd_last_o) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_i) begin
            state_d = StIdle;
        end
    end

    // rst_q keeps blk_ready low for the cycle that follows a sampled reset.
    always_comb begin
        blk_ready_o = 1'b0;
        rnd_valid_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            StIdle:  blk_ready_o = ~rst_q;
            StRun: begin
                rnd_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            StDone: begin
                done_o = 1'b1;
                busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign rnd_idx_o  = t_q;
    assign rnd_w_o    = win_q[0];
    assign rnd_last_o = rnd_valid_o & (t_q == LastIdx);

    always_comb begin
        win_d = win_q;
        t_d   = t_q;
        if (abort_i) begin
            t_d = '0;
        end else if (blk_hs) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = blk_data_i[i*WORD_S +: WORD_S];
            end
            t_d = '0;
        end else if (rnd_hs) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
            t_d       = t_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            t_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            t_q   <= t_d;
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_sha_sched_ctrl.sv
// Randomised scoreboard bench for sha_sched_ctrl: a reference schedule expansion predicts
// every round; a negedge monitor pops and compares on each round handshake.
module tb_sha_sched_ctrl;

    localparam int R = 64;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
        logic        last;
    } rnd_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_valid17 = 1'b0;
    logic [511:0] blk_data = '0;
    logic         abort = 1'b0;
    logic         rnd_ready = 1'b0;
    int           rr_mode = 1;

    logic         blk_ready, rnd_valid, rnd_last, done, busy;
    logic [5:0]   rnd_idx;
    logic [31:0]  rnd_w;
    logic         blk_ready17, rnd_valid17, rnd_last17, done17, busy17;
    logic [5:0]   rnd_idx17;
    logic [31:0]  rnd_w17;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
    rnd_t         sb [$];
    logic [31:0]  model_w [64];
    logic [31:0]  cap [64];
    logic [31:0]  gold [64];

    always #5 clk = ~clk;

    sha_sched_ctrl #(.ROUNDS(R), .WORD_S(32)) u_dut (
        .clk_i(clk), .reset_i(reset), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
        .blk_data_i(blk_data), .abort_i(abort), .rnd_valid_o(rnd_valid),
        .rnd_ready_i(rnd_ready), .rnd_idx_o(rnd_idx), .rnd_w_o(rnd_w),
        .rnd_last_o(rnd_last), .done_o(done), .busy_o(busy)
    );

    sha_sched_ctrl #(.ROUNDS(17), .WORD_S(32)) u_dut17 (
        .clk_i(clk), .reset_i(reset), .blk_valid_i(blk_valid17), .blk_ready_o(blk_ready17),
        .blk_data_i(blk_data), .abort_i(abort), .rnd_valid_o(rnd_valid17),
        .rnd_ready_i(rnd_ready), .rnd_idx_o(rnd_idx17), .rnd_w_o(rnd_w17),
        .rnd_last_o(rnd_last17), .done_o(done17), .busy_o(busy17)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook SHA-256 schedule recurrence over the whole W array.
    task automatic expand(input logic [511:0] b);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) model_w[i] = b[i*32 +: 32];
            else model_w[i] = s1(model_w[i-2]) + model_w[i-7] + s0(model_w[i-15]) + model_w[i-16];
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       rnd_ready = 1'b0;
            1:       rnd_ready = 1'b1;
            default: rnd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard
    logic chk_zero = 1'b0, exp_done = 1'b0, exp_idle = 1'b0, exp_first = 1'b0;
    logic stall_v = 1'b0;
    rnd_t stall_s;
    always @(negedge clk) begin
        rnd_t e;
        cyc++;
        if (chk_zero)
            check("reset_outputs_zero", {blk_ready, rnd_valid, rnd_idx, rnd_w, rnd_last, done, busy}, 0);
        chk_zero = reset;
        if (reset) begin
            sb.delete();
            exp_done = 0; exp_idle = 0; exp_first = 0; stall_v = 0;
        end else begin
            if (exp_done || done) check("done_timing", done, exp_done);
            exp_done = 0;
            if (exp_idle) check("idle_after_abort", {rnd_valid, busy, done, blk_ready}, 4'b0001);
            exp_idle = 0;
            if (exp_first) check("first_round_latency", {rnd_valid, rnd_idx}, {1'b1, 6'd0});
            exp_first = 0;
            if (stall_v) check("stall_stable", {rnd_valid, rnd_idx, rnd_w, rnd_last}, {1'b1, stall_s});
            stall_v = 0;
            if (busy && blk_ready) check("blk_ready_low_when_busy", blk_ready, 0);
            if (done && rnd_valid) check("no_valid_in_done", rnd_valid, 0);
            if (abort) begin
                sb.delete();
                exp_idle = 1;
            end else begin
                if (blk_valid && blk_ready) begin
                    expand(blk_data);
                    for (int i = 0; i < R; i++) sb.push_back({6'(i), model_w[i], i == R - 1});
                    exp_first = 1;
                    acc_cnt++;
                    acc_cyc = cyc;
                end
                if (rnd_valid && rnd_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_round", {rnd_idx, rnd_w}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("round", {rnd_idx, rnd_w, rnd_last}, e);
                        cap[rnd_idx] = rnd_w;
                        if (rnd_last) exp_done = 1;
                    end
                end
                if (rnd_valid && !rnd_ready) begin
                    stall_v = 1;
                    stall_s = {rnd_idx, rnd_w, rnd_last};
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic wait_acc(input int n, input int bound, input string name);
        int k;
        for (k = 0; k < bound; k++) begin
            @(posedge clk);
            if (acc_cnt != n) break;
        end
        if (k == bound) check({name, "_accept_timeout"}, 1, 0);
    endtask

    task automatic send_block(input logic [511:0] b);
        int n = acc_cnt;
        @(posedge clk); #1;
        blk_valid = 1'b1;
        blk_data  = b;
        wait_acc(n, 200, "send");
        #1 blk_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = done_cnt;
        int k;
        for (k = 0; k < bound; k++) begin
            @(posedge clk);
            if (done_cnt != n) break;
        end
        if (k == bound) check({name, "_done_timeout"}, 1, 0);
        check({name, "_scoreboard_drained"}, sb.size(), 0);
    endtask

    task automatic wait_idx(input int idx, input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (rnd_valid && rnd_idx == 6'(idx)) break;
        end
        if (k == 200) check({name, "_idx_timeout"}, 1, 0);
    endtask

    initial begin
        logic [511:0] abc, b;
        int n;
        int k;
        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("blk_ready_after_reset", {blk_ready, busy, rnd_valid}, 3'b100);

        // Golden vector at full throughput
        rr_mode = 1;
        send_block(abc);
        wait_done(200, "golden");
        check("gold_w0", cap[0], 32'h61626380);
        check("gold_w15", cap[15], 32'h00000018);
        check("gold_w16", cap[16], 32'h61626380);
        check("gold_w17", cap[17], 32'h000F0000);
        check("gold_w18", cap[18], 32'h7DA86405);
        check("gold_throughput", done_cyc - acc_cyc, R + 1);
        for (int i = 0; i < 64; i++) gold[i] = cap[i];

        // Same block under random backpressure
        for (int i = 0; i < 64; i++) cap[i] = '0;
        rr_mode = 2;
        send_block(abc);
        wait_done(2000, "backpressure");
        for (int i = 0; i < 64; i++) check($sformatf("bp_w%0d", i), cap[i], gold[i]);

        // Abort in IDLE with a block offered: not accepted
        rr_mode = 1;
        n = acc_cnt;
        @(posedge clk); #1;
        blk_valid = 1'b1; abort = 1'b1; blk_data = rand_block();
        @(posedge clk); #1;
        blk_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_idle_no_accept", acc_cnt, n);

        // Back-to-back with blk_valid held high
        n = acc_cnt;
        @(posedge clk); #1;
        blk_valid = 1'b1; blk_data = rand_block();
        wait_acc(n, 200, "b2b_first");
        #1 blk_data = rand_block();
        wait_acc(n + 1, 200, "b2b_second");
        #1 blk_valid = 1'b0;
        check("b2b_accept_after_done", acc_cyc, done_cyc + 1);
        wait_done(200, "b2b");

        // Abort at t=20 while rnd_ready is high
        send_block(rand_block());
        wait_idx(20, "abort");
        n = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (4) @(posedge clk);
        check("abort_no_done", done_cnt, n);
        send_block(rand_block());
        wait_done(200, "after_abort");

        // Reset at t=40
        send_block(rand_block());
        wait_idx(40, "reset");
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("blk_ready_after_mid_reset", blk_ready, 1);
        send_block(rand_block());
        wait_done(200, "after_reset");

        // ROUNDS=17 instance
        b = rand_block();
        expand(b);
        @(posedge clk); #1;
        blk_valid17 = 1'b1; blk_data = b;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (blk_ready17) break;
        end
        @(posedge clk); #1 blk_valid17 = 1'b0;
        n = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rnd_valid17) begin
                check($sformatf("r17_round%0d", n), {rnd_idx17, rnd_w17, rnd_last17},
                      {6'(n), model_w[n], n == 16});
                n++;
            end
            if (done17) break;
        end
        check("r17_done_seen", done17, 1);
        check("r17_round_count", n, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_sched_ctrl.md
Name: sha_sched_ctrl

Overview:
- Round sequencer for the SHA-256 message schedule in the bitcoin miner pipeline.
- Accepts one 512-bit padded message block over a valid/ready handshake.
- Holds the block in a 16-word sliding window and expands it one word per accepted round.
- Streams one W word per round, with its round index, to the compression datapath over a second valid/ready handshake. The compression core indexes its K ROM by that round index.
- Completes with a one-cycle done pulse; supports synchronous abort when a nonce is abandoned.

Parameters:
- ROUNDS, 64, number of rounds streamed per block; legal range 17..64.
- WORD_S, 32, SHA-256 word width in bits; fixed at 32, parameterised for readability only.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- blk_valid  in  1  blk_data holds a valid block.
- blk_ready  out  1  controller can accept a block (high only in IDLE).
- blk_data  in  512  message block; word i is blk_data[i*32 +: 32]; W[0] is bits [31:0].
- abort  in  1  drop the current block and return to IDLE.
- rnd_valid  out  1  rnd_w/rnd_idx/rnd_last are valid.
- rnd_ready  in  1  compression datapath consumes the round this cycle.
- rnd_idx  out  6  round number t, 0..ROUNDS-1.
- rnd_w  out  32  message schedule word W[t].
- rnd_last  out  1  high with rnd_valid when t == ROUNDS-1.
- done  out  1  one-cycle pulse after the last round is consumed.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset: one clock, synchronous, active-high. While reset is high at a clk edge, the next state is IDLE, t=0 and window words = 0. All outputs are 0 during the reset cycle (blk_ready included). blk_ready rises the first cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - blk_ready=1, rnd_valid=0, busy=0.
  - On blk_valid&blk_ready: win[i] <= word i, t <= 0, go to RUN.
  - The first round is therefore presented the cycle after acceptance (latency 1).
- RUN:
  - rnd_valid=1, busy=1, blk_ready=0.
  - rnd_w = win[0], rnd_idx = t; all outputs driven directly from registers, no combinational path from rnd_ready.
  - rnd_last = (t == ROUNDS-1).
  - On rnd_valid&rnd_ready (handshake):
    - win[i] <= win[i+1] for i = 0..14.
    - win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0], with addition mod 2^32.
    - t <= t+1.
    - If rnd_last, go to DONE instead.
- Stall: rnd_ready=0 holds t, the window and all outputs bit-stable. rnd_valid is never withdrawn without a handshake, except on abort or reset.
- Expansion functions:
  - sig0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sig1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Rounds 0..15 emit the loaded words unchanged; rounds 16+ emit expanded words.
- Throughput: with rnd_ready held high, one round per cycle, ROUNDS consecutive cycles.
- DONE:
  - done=1 for exactly one cycle; rnd_valid=0; busy=1; blk_ready=0.
  - Next state is IDLE unconditionally.
  - Minimum block-to-block spacing is ROUNDS+2 cycles.
- Abort:
  - Sampled in every state; next state is IDLE and t <= 0. The window is not cleared.
  - Abort has priority over both the round handshake and the block handshake in the same cycle. The round is not consumed, the block is not accepted, and done is not pulsed.
  - Outputs reflect IDLE the following cycle.
  - Abort in IDLE is a no-op, including when blk_valid is high: that block is not accepted.
- Reset has priority over abort.
- blk_data is ignored outside the accepting cycle.

Test Plan:
- Golden vector: load the padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) with rnd_ready=1. Required:
  - rnd_w = 0x61626380 at t=0 and 0x00000018 at t=15.
  - t=16 -> 0x61626380, t=17 -> 0x000F0000, t=18 -> 0x7DA86405.
  - All 64 words match the reference model.
  - rnd_last only at t=63; done exactly one cycle after the t=63 handshake.
- Backpressure: same block with rnd_ready random (50%) -> identical word sequence. Outputs stable across every stall cycle; no skipped or duplicated rnd_idx.
- Back-to-back: blk_valid held high with two different blocks -> second accepted exactly the cycle after done. blk_ready=0 throughout RUN/DONE. Second block's stream is correct.
- Abort mid-stream: abort at t=20 with rnd_ready=1 in the same cycle -> round 20 not consumed, no done pulse, rnd_valid=0 next cycle. A new block then streams correctly from t=0.
- Reset mid-operation: reset asserted at t=40 -> next cycle all outputs 0. After release, blk_ready=1 and a fresh block is processed normally.
- ROUNDS=17 build: exactly 17 rounds; rnd_last at t=16 with rnd_w equal to expanded W[16].
